// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer for the 16-bit instruction register. Owns the
//   PC and pulls one instruction over the 8-bit memory bus as two bytes, low
//   byte first. The low byte goes to the IR as a full-word write
//   ({8'h00,byte}). The high byte goes in as an upper-byte write.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     start               fetch one instruction at the current PC
//     pc_load, pc_in      load a new PC (aborts any fetch in progress)
//     mem_ack, mem_din    memory byte-read completion and data
//     mem_rd, mem_addr    memory read request and byte address
//     ir_din              IR data input
//     ir_write            IR full-word write strobe (low byte)
//     ir_writeu           IR upper-byte write strobe (high byte)
//     pc_out              current PC
//     busy                fetch in progress
//     done                instruction fully loaded (coincides with ir_writeu)
//     err                 sticky memory timeout flag, cleared by pc_load
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [15:0] ir_din,
    output logic        ir_write,
    output logic        ir_writeu,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, ERR} state_t;

    localparam logic [15:0] TO = TIMEOUT[15:0];

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ir_din_q, ir_din_d;
    logic [15:0] wait_q, wait_d;
    logic        rd_q, rd_d;
    logic        ir_write_q, ir_write_d;
    logic        ir_writeu_q, ir_writeu_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        ir_din_d    = ir_din_q;
        wait_d      = wait_q;
        rd_d        = rd_q;
        err_d       = err_q;
        ir_write_d  = 1'b0;
        ir_writeu_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (start) begin
                    addr_d  = pc_q;
                    rd_d    = 1'b1;
                    wait_d  = 16'd0;
                    state_d = RD_LO;
                end
            end
            RD_LO, RD_HI: begin
                // pc_load outranks a same-cycle ack: the byte is dropped.
                if (pc_load) begin
                    pc_d    = pc_in;
                    rd_d    = 1'b0;
                    wait_d  = 16'd0;
                    state_d = IDLE;
                end else if (mem_ack) begin
                    ir_din_d = {8'h00, mem_din};
                    pc_d     = pc_q + 16'd1;
                    wait_d   = 16'd0;
                    if (state_q == RD_LO) begin
                        ir_write_d = 1'b1;
                        addr_d     = pc_q + 16'd1;  // rd stays high into the high byte
                        state_d    = RD_HI;
                    end else begin
                        ir_writeu_d = 1'b1;
                        done_d      = 1'b1;
                        rd_d        = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (TIMEOUT > 0) begin
                    if (wait_q + 16'd1 == TO) begin
                        rd_d    = 1'b0;
                        err_d   = 1'b1;
                        wait_d  = 16'd0;
                        state_d = ERR;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            ERR: begin
                if (pc_load) begin
                    pc_d    = pc_in;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RD_LO) || (state_d == RD_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            ir_din_q    <= 16'h0000;
            wait_q      <= 16'd0;
            rd_q        <= 1'b0;
            ir_write_q  <= 1'b0;
            ir_writeu_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            ir_din_q    <= ir_din_d;
            wait_q      <= wait_d;
            rd_q        <= rd_d;
            ir_write_q  <= ir_write_d;
            ir_writeu_q <= ir_writeu_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_rd    = rd_q;
    assign mem_addr  = addr_q;
    assign ir_din    = ir_din_q;
    assign ir_write  = ir_write_q;
    assign ir_writeu = ir_writeu_q;
    assign pc_out    = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model tracks fetch progress (which byte is outstanding, how long
//   memory has stalled) and predicts every output each cycle. Byte data comes
//   from a 64K memory image, so IR contents are predicted from the image.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          TMO    = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic        mem_rd, ir_write, ir_writeu, busy, done, err;
    logic [15:0] mem_addr, ir_din, pc_out;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc_load(pc_load), .pc_in(pc_in),
        .mem_ack(mem_ack), .mem_din(mem_din), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .ir_din(ir_din), .ir_write(ir_write), .ir_writeu(ir_writeu), .pc_out(pc_out),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    // Reference model: bytes_left = 0 (no fetch), 2 (low outstanding), 1 (high outstanding)
    int          bytes_left;
    bit          m_fault;
    int          stall;
    logic [15:0] m_pc, m_addr, m_ir;
    bit          m_rd, m_wr, m_wru, m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bytes_left = 0; m_fault = 0; stall = 0;
        m_pc = RST_PC; m_addr = RST_PC; m_ir = 16'h0000;
        m_rd = 0; m_wr = 0; m_wru = 0; m_done = 0;
    endtask

    task automatic model_next(input bit st, input bit pl, input logic [15:0] pin,
                              input bit ack, input logic [7:0] din);
        m_wr = 0; m_wru = 0; m_done = 0;
        if (m_fault) begin
            if (pl) begin m_pc = pin; m_fault = 0; end
        end else if (bytes_left == 0) begin
            if (pl) m_pc = pin;
            else if (st) begin bytes_left = 2; m_addr = m_pc; m_rd = 1; stall = 0; end
        end else if (pl) begin
            bytes_left = 0; m_pc = pin; m_rd = 0;
        end else if (ack) begin
            m_ir = {8'h00, din};
            m_pc = m_pc + 16'd1;
            stall = 0;
            bytes_left--;
            if (bytes_left == 1) begin m_wr = 1; m_addr = m_pc; end
            else begin m_wru = 1; m_done = 1; m_rd = 0; end
        end else begin
            stall++;
            if (TMO > 0 && stall >= TMO) begin bytes_left = 0; m_rd = 0; m_fault = 1; end
        end
    endtask

    task automatic check_outs();
        chk("mem_rd", 32'(mem_rd), 32'(m_rd));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("ir_din", 32'(ir_din), 32'(m_ir));
        chk("ir_write", 32'(ir_write), 32'(m_wr));
        chk("ir_writeu", 32'(ir_writeu), 32'(m_wru));
        chk("done", 32'(done), 32'(m_done));
        chk("pc_out", 32'(pc_out), 32'(m_pc));
        chk("busy", 32'(busy), 32'(bytes_left != 0));
        chk("err", 32'(err), 32'(m_fault));
        chk("strobe_excl", 32'(ir_write & ir_writeu), 32'd0);
    endtask

    // One clock: drive inputs, advance model, check just after the edge.
    task automatic cyc(input bit st, input bit pl, input logic [15:0] pin, input bit ack);
        start = st; pc_load = pl; pc_in = pin; mem_ack = ack;
        mem_din = (ack && m_rd) ? mem[m_addr] : 8'($urandom);
        model_next(st, pl, pin, ack, mem_din);
        @(posedge clk); #1;
        check_outs();
    endtask

    // Fetch with a fixed number of stall cycles before each ack; returns
    // cycles from the start edge to the done edge and strobe counts.
    task automatic fetch(input int dly, output int cycles, output int n_wr, output int n_wru);
        int cnt;
        cnt = 0; n_wr = 0; n_wru = 0;
        cyc(1, 0, 16'h0000, 0);
        cycles = 1;
        for (int i = 0; i < 200 && bytes_left != 0; i++) begin
            cyc(0, 0, 16'h0000, cnt == dly);
            cnt = (cnt == dly) ? 0 : cnt + 1;
            cycles++;
            n_wr += int'(ir_write);
            n_wru += int'(ir_writeu);
        end
        if (bytes_left != 0) chk("fetch_bound", 32'd1, 32'd0);
    endtask

    initial begin
        int cy, nw, nwu;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h12;

        // Reset state
        model_reset();
        #2 check_outs();
        @(posedge clk); #1 rst_n = 1'b1;

        // Zero-wait fetch of 0x1234 at 0x0000
        cyc(1, 0, 16'h0000, 0);
        chk("t1_mem_rd", 32'(mem_rd), 32'd1);
        cyc(0, 0, 16'h0000, 1);
        chk("t2_ir_write", 32'(ir_write), 32'd1);
        chk("t2_ir_din", 32'(ir_din), 32'h0034);
        cyc(0, 0, 16'h0000, 1);
        chk("t3_done", 32'(done & ir_writeu), 32'd1);
        chk("t3_ir_din", 32'(ir_din), 32'h0012);
        chk("t3_pc", 32'(pc_out), 32'h0002);

        // Start accepted straight after done; 3 stall cycles per byte
        fetch(3, cy, nw, nwu);
        chk("dly_cycles", 32'(cy), 32'd9);   // 1 + 2 * (3 stalls + ack cycle)
        chk("dly_nwr", 32'(nw), 32'd1);
        chk("dly_nwru", 32'(nwu), 32'd1);
        cyc(0, 0, 16'h0000, 0);
        chk("dly_rd_low", 32'(mem_rd), 32'd0);

        // PC wrap between bytes
        cyc(0, 1, 16'hFFFF, 0);
        fetch(0, cy, nw, nwu);
        chk("wrap_pc", 32'(pc_out), 32'h0001);
        chk("wrap_ir", 32'(ir_din), {24'h0, mem[0]});

        // pc_load with ack in high byte: abort
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 1, 16'h0100, 1);
        chk("abort_writeu", 32'(ir_writeu | done), 32'd0);
        chk("abort_pc", 32'(pc_out), 32'h0100);
        chk("abort_busy", 32'(busy), 32'd0);

        // Timeout, start ignored in fault, pc_load clears
        cyc(1, 0, 16'h0000, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 16'h0000, 0);
        chk("to_pre_err", 32'(err), 32'd0);
        cyc(0, 0, 16'h0000, 0);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rd", 32'(mem_rd), 32'd0);
        cyc(1, 0, 16'h0000, 0);
        chk("to_start_ign", 32'(mem_rd), 32'd0);
        cyc(0, 1, 16'h0200, 0);
        chk("to_clear", 32'(err), 32'd0);

        // Asynchronous reset mid-fetch
        cyc(1, 0, 16'h0000, 0);
        #1 rst_n = 1'b0;
        start = 0; pc_load = 0; mem_ack = 0;
        #1;
        chk("arst_rd", 32'(mem_rd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pc", 32'(pc_out), 32'(RST_PC));
        model_reset();
        check_outs();
        #2 rst_n = 1'b1;
        cyc(0, 0, 16'h0000, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit st, pl, ak;
            st = ($urandom_range(0, 2) == 0);
            pl = ($urandom_range(0, 24) == 0);
            ak = m_rd ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            if (i % 1000 == 500) begin
                // force a stall long enough to hit the timeout
                for (int k = 0; k < 20; k++) cyc(k == 0, 0, 16'h0000, 0);
            end
            cyc(st, pl, 16'($urandom), ak);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
